conv_ctrl: RTL and testbench
============================

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 Parameters: MEM_LAT, default 1, cycles from act_rd_en/wgt_rd_en to data at conv_top inputs.
REQ-002 Parameters: PIPE_LAT, default 4, cycles from conv_top input sample to valid out_acivation.
REQ-003 Parameters: GRP_BW, default 3, width of output-channel-group index.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle layer-start request.
REQ-007 map_w, map_h  in  8 each  feature-map columns, rows; valid 1..255.
REQ-008 grp_num  in  GRP_BW  number of output-channel groups to run; valid 1..2^GRP_BW-1.
REQ-009 relu_cfg, residual_cfg  in  1 each  layer mode bits.
REQ-010 stall  in  1  activation source not ready; blocks pixel issue.
REQ-011 busy  out  1  high from accepted start through done.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 wgt_rd_en  out  1; wgt_grp  out  GRP_BW  weight/bias fetch request and group index.
REQ-014 act_rd_en  out  1; act_row, act_col  out  8 each  3x3 window fetch request and centre position.
REQ-015 relu, residual  out  1 each  latched mode bits driven to conv_top.
REQ-016 out_wr_en  out  1; out_row, out_col  out  8 each; out_grp  out  GRP_BW  result write tag.

Function
REQ-017 States SHALL be IDLE, WLOAD, WWAIT, RUN, DRAIN, DONE.
REQ-018 IDLE: start with map_w, map_h, grp_num all nonzero SHALL latch config, clear grp/row/col counters, go WLOAD; otherwise start ignored.
REQ-019 start in any state other than IDLE SHALL be ignored; latched config stays constant until IDLE.
REQ-020 WLOAD: one cycle, wgt_rd_en=1, wgt_grp=current group, then WWAIT.
REQ-021 WWAIT: MEM_LAT cycles, then RUN; stall ignored in WLOAD/WWAIT.
REQ-022 RUN: each cycle with stall=0 SHALL assert act_rd_en with current (row,col), then advance col; col wraps map_w-1->0 and increments row.
REQ-023 RUN with stall=1: act_rd_en=0, counters held.
REQ-024 Issue of (map_h-1,map_w-1): if group < grp_num-1, increment group, clear row/col, go WLOAD next cycle; else go DRAIN.
REQ-025 Tag pipeline depth D=MEM_LAT+PIPE_LAT carries {valid,row,col,grp}; shifts every cycle regardless of stall (stall inserts bubbles).
REQ-026 act_rd_en at cycle t SHALL produce out_wr_en at t+D with identical row, col, grp; no other out_wr_en.
REQ-027 DRAIN: hold until tag pipeline empty, then DONE; DONE asserts done for one cycle, returns IDLE.
REQ-028 done SHALL occur exactly the cycle after the final out_wr_en; busy deasserts the cycle after done.
REQ-029 Total out_wr_en count per layer SHALL equal map_w*map_h*grp_num.
REQ-030 relu/residual SHALL equal latched cfg while busy, 0 in IDLE.
REQ-031 wgt_rd_en and act_rd_en SHALL never be high in the same cycle.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, clear counters, config, tag pipeline valids, and drive all outputs 0, including mid-layer; no out_wr_en after reset from pre-reset issues.
REQ-033 After rst_n release, first accepted start SHALL behave as from power-up.

Verification
REQ-034 map_w=3, map_h=2, grp_num=1, stall=0, start at cycle 0 -> wgt_rd_en cycle 1; act_rd_en cycles 3..8 order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); out_wr_en cycles 8..13 same order; done cycle 14.
REQ-035 Same config, grp_num=2 -> second wgt_rd_en with wgt_grp=1 immediately after (1,2) issue; 12 out_wr_en total, out_grp 0 then 1.
REQ-036 map_w=4, map_h=1, stall high for 3 cycles after second issue -> act_rd_en gaps of 3 cycles, out_wr_en shows same 3-cycle gap, positions unchanged, done after 4th write.
REQ-037 start with map_w=0, and start while busy -> ignored, busy unchanged, no wgt_rd_en.
REQ-038 rst_n low two cycles after RUN begins -> all outputs 0 same cycle, no out_wr_en thereafter; new start completes normally.
REQ-039 map_w=255, map_h=1 -> col wraps to 0 with row increment only at final issue, 255 writes, no overflow.

Source files
------------

// File: rtl/conv_ctrl.sv
// Convolution layer sequencer: per output-channel group, fetches weights, then issues
// one 3x3 window fetch per pixel and tags each issue so its result write comes out D cycles later.
//
// state | meaning
// IDLE  | waiting for a valid start; outputs quiet
// WLOAD | one-cycle weight/bias fetch for the current group
// WWAIT | wait for weight memory latency
// RUN   | issue one window per non-stalled cycle, raster order
// DRAIN | no more issues; wait for in-flight tags to retire
// DONE  | one-cycle completion pulse
module conv_ctrl #(
    parameter int MEM_LAT  = 1,
    parameter int PIPE_LAT = 4,
    parameter int GRP_BW   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        map_w,
    input  logic [7:0]        map_h,
    input  logic [GRP_BW-1:0] grp_num,
    input  logic              relu_cfg,
    input  logic              residual_cfg,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              wgt_rd_en,
    output logic [GRP_BW-1:0] wgt_grp,
    output logic              act_rd_en,
    output logic [7:0]        act_row,
    output logic [7:0]        act_col,
    output logic              relu,
    output logic              residual,
    output logic              out_wr_en,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic [GRP_BW-1:0] out_grp
);

    localparam int D     = MEM_LAT + PIPE_LAT;
    localparam int WW_BW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {IDLE, WLOAD, WWAIT, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic              vld;
        logic [7:0]        row;
        logic [7:0]        col;
        logic [GRP_BW-1:0] grp;
    } tag_t;

    state_t            state_q, state_d;
    logic [7:0]        map_w_q, map_h_q;
    logic [GRP_BW-1:0] grp_num_q;
    logic              relu_q, residual_q;
    logic [GRP_BW-1:0] grp_q, grp_d;
    logic [7:0]        row_q, row_d;
    logic [7:0]        col_q, col_d;
    logic [WW_BW-1:0]  wait_q, wait_d;
    logic              cfg_ld;
    logic              pipe_busy;
    tag_t              tag_q [D];

    // Entries that survive the next shift; the last stage is retiring this cycle.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < D - 1; i++) begin
            pipe_busy = pipe_busy | tag_q[i].vld;
        end
    end

    always_comb begin
        state_d   = state_q;
        grp_d     = grp_q;
        row_d     = row_q;
        col_d     = col_q;
        wait_d    = wait_q;
        cfg_ld    = 1'b0;
        wgt_rd_en = 1'b0;
        act_rd_en = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (map_w != 8'd0) && (map_h != 8'd0) && (grp_num != '0)) begin
                    cfg_ld  = 1'b1;
                    grp_d   = '0;
                    row_d   = 8'd0;
                    col_d   = 8'd0;
                    state_d = WLOAD;
                end
            end
            WLOAD: begin
                wgt_rd_en = 1'b1;
                wait_d    = WW_BW'(MEM_LAT - 1);
                state_d   = WWAIT;
            end
            WWAIT: begin
                if (wait_q == '0) begin
                    state_d = RUN;
                end else begin
                    wait_d = wait_q - WW_BW'(1);
                end
            end
            RUN: begin
                if (!stall) begin
                    act_rd_en = 1'b1;
                    if (col_q == map_w_q - 8'd1) begin
                        col_d = 8'd0;
                        if (row_q == map_h_q - 8'd1) begin
                            row_d = 8'd0;
                            if (grp_q == grp_num_q - GRP_BW'(1)) begin
                                state_d = DRAIN;
                            end else begin
                                grp_d   = grp_q + GRP_BW'(1);
                                state_d = WLOAD;
                            end
                        end else begin
                            row_d = row_q + 8'd1;
                        end
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grp_q      <= '0;
            row_q      <= 8'd0;
            col_q      <= 8'd0;
            wait_q     <= '0;
            map_w_q    <= 8'd0;
            map_h_q    <= 8'd0;
            grp_num_q  <= '0;
            relu_q     <= 1'b0;
            residual_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wait_q  <= wait_d;
            if (cfg_ld) begin
                map_w_q    <= map_w;
                map_h_q    <= map_h;
                grp_num_q  <= grp_num;
                relu_q     <= relu_cfg;
                residual_q <= residual_cfg;
            end
        end
    end

    // Shifts every cycle; a stalled cycle enters as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: act_rd_en, row: row_q, col: col_q, grp: grp_q};
            for (int i = 1; i < D; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign relu      = relu_q & busy;
    assign residual  = residual_q & busy;
    assign wgt_grp   = grp_q;
    assign act_row   = row_q;
    assign act_col   = col_q;
    assign out_wr_en = tag_q[D-1].vld;
    assign out_row   = tag_q[D-1].row;
    assign out_col   = tag_q[D-1].col;
    assign out_grp   = tag_q[D-1].grp;

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl with default parameters (MEM_LAT=1, PIPE_LAT=4).
// Events are logged relative to the start cycle and compared against hand-derived timing.
module tb_conv_ctrl;

    localparam int GRP_BW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        map_w = 8'd0;
    logic [7:0]        map_h = 8'd0;
    logic [GRP_BW-1:0] grp_num = '0;
    logic              relu_cfg = 1'b0;
    logic              residual_cfg = 1'b0;
    logic              stall = 1'b0;
    logic              busy, done, wgt_rd_en, act_rd_en, relu, residual, out_wr_en;
    logic [GRP_BW-1:0] wgt_grp, out_grp;
    logic [7:0]        act_row, act_col, out_row, out_col;
    logic              any_out;

    conv_ctrl #(.MEM_LAT(1), .PIPE_LAT(4), .GRP_BW(GRP_BW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .map_w(map_w), .map_h(map_h), .grp_num(grp_num),
        .relu_cfg(relu_cfg), .residual_cfg(residual_cfg), .stall(stall),
        .busy(busy), .done(done),
        .wgt_rd_en(wgt_rd_en), .wgt_grp(wgt_grp),
        .act_rd_en(act_rd_en), .act_row(act_row), .act_col(act_col),
        .relu(relu), .residual(residual),
        .out_wr_en(out_wr_en), .out_row(out_row), .out_col(out_col), .out_grp(out_grp)
    );

    assign any_out = |{busy, done, wgt_rd_en, wgt_grp, act_rd_en, act_row, act_col,
                       relu, residual, out_wr_en, out_row, out_col, out_grp};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail = 0;
    int          t0 = 0;
    int          busy_last = -1;
    int          overlap = 0;
    int          mode_err = 0;
    bit          exp_rl = 1'b0;
    bit          exp_rs = 1'b0;
    logic [31:0] wgt_q[$];
    logic [31:0] act_q[$];
    logic [31:0] out_q[$];
    int          done_q[$];

    function automatic logic [31:0] pk(input int c, input int r, input int col, input int g);
        logic [31:0] v;
        v = {c[11:0], r[7:0], col[7:0], g[3:0]};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (wgt_rd_en) wgt_q.push_back(pk(rel, 0, 0, int'(wgt_grp)));
        if (act_rd_en) act_q.push_back(pk(rel, int'(act_row), int'(act_col), 0));
        if (out_wr_en) out_q.push_back(pk(rel, int'(out_row), int'(out_col), int'(out_grp)));
        if (done) done_q.push_back(rel);
        if (busy) busy_last = rel;
        if (wgt_rd_en && act_rd_en) overlap++;
        if (busy ? ((relu !== exp_rl) || (residual !== exp_rs)) : (relu || residual)) mode_err++;
    end

    // re_at: cycle of a second start pulse with different config; rs_at: cycle to pulse reset.
    task automatic run_layer(input int w, input int h, input int g, input bit rl, input bit rs,
                             input int st_at, input int st_len, input int re_at, input int rs_at,
                             input int budget);
        int rel;
        wgt_q.delete(); act_q.delete(); out_q.delete(); done_q.delete();
        busy_last = -1; overlap = 0; mode_err = 0;
        exp_rl = rl; exp_rs = rs;
        @(posedge clk); #1;
        map_w = 8'(w); map_h = 8'(h); grp_num = GRP_BW'(g);
        relu_cfg = rl; residual_cfg = rs;
        start = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rel = cyc - t0;
            stall = (st_len > 0) && (rel >= st_at) && (rel < st_at + st_len);
            if (rel == re_at) begin
                start = 1'b1;
                map_w = 8'd1; map_h = 8'd1; grp_num = GRP_BW'(3);
                relu_cfg = ~rl; residual_cfg = ~rs;
            end
            if (rel == rs_at) begin
                rst_n = 1'b0;
                #1 chk("rst_outs_zero", 32'(any_out), 32'd0);
            end
            if (rel == rs_at + 2) rst_n = 1'b1;
            if (done_q.size() > 0 && rel >= done_q[0] + 2) break;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    // Unstalled timing: group period = WLOAD + WWAIT + w*h issues; results D=5 cycles later.
    task automatic check_model(input string nm, input int w, input int h, input int g);
        int p, n, e, gi, k, last_done;
        p = 2 + w * h;
        n = w * h;
        chk({nm, "_wgt_n"}, wgt_q.size(), g);
        for (int i = 0; i < g && i < wgt_q.size(); i++)
            chk({nm, "_wgt"}, wgt_q[i], pk(1 + i * p, 0, 0, i));
        chk({nm, "_act_n"}, act_q.size(), n * g);
        chk({nm, "_out_n"}, out_q.size(), n * g);
        for (e = 0; e < n * g && e < act_q.size(); e++) begin
            gi = e / n; k = e % n;
            chk({nm, "_act"}, act_q[e], pk(3 + gi * p + k, k / w, k % w, 0));
        end
        for (e = 0; e < n * g && e < out_q.size(); e++) begin
            gi = e / n; k = e % n;
            chk({nm, "_out"}, out_q[e], pk(8 + gi * p + k, k / w, k % w, gi));
        end
        last_done = 3 + (g - 1) * p + n - 1 + 5 + 1;
        chk({nm, "_done_n"}, done_q.size(), 1);
        if (done_q.size() > 0) chk({nm, "_done_cyc"}, done_q[0], last_done);
        chk({nm, "_busy_last"}, busy_last, last_done);
        chk({nm, "_rd_overlap"}, overlap, 0);
        chk({nm, "_mode"}, mode_err, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk("reset_outs_zero", 32'(any_out), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_layer(3, 2, 1, 1'b1, 1'b0, -1, 0, -1, -1, 60);
        check_model("basic_3x2", 3, 2, 1);

        run_layer(3, 2, 2, 1'b0, 1'b1, -1, 0, -1, -1, 80);
        check_model("two_grp", 3, 2, 2);

        run_layer(4, 1, 1, 1'b1, 1'b1, 5, 3, -1, -1, 60);
        chk("stall_wgt_n", wgt_q.size(), 1);
        chk("stall_act_n", act_q.size(), 4);
        chk("stall_out_n", out_q.size(), 4);
        if (act_q.size() == 4) begin
            chk("stall_act0", act_q[0], pk(3, 0, 0, 0));
            chk("stall_act1", act_q[1], pk(4, 0, 1, 0));
            chk("stall_act2", act_q[2], pk(8, 0, 2, 0));
            chk("stall_act3", act_q[3], pk(9, 0, 3, 0));
        end
        if (out_q.size() == 4) begin
            chk("stall_out0", out_q[0], pk(8, 0, 0, 0));
            chk("stall_out1", out_q[1], pk(9, 0, 1, 0));
            chk("stall_out2", out_q[2], pk(13, 0, 2, 0));
            chk("stall_out3", out_q[3], pk(14, 0, 3, 0));
        end
        chk("stall_done_n", done_q.size(), 1);
        if (done_q.size() > 0) chk("stall_done_cyc", done_q[0], 15);

        run_layer(0, 2, 1, 1'b1, 1'b0, -1, 0, -1, -1, 12);
        chk("bad_w_wgt_n", wgt_q.size(), 0);
        chk("bad_w_busy", busy_last, -1);
        run_layer(2, 2, 0, 1'b1, 1'b0, -1, 0, -1, -1, 12);
        chk("bad_g_wgt_n", wgt_q.size(), 0);
        chk("bad_g_busy", busy_last, -1);

        run_layer(3, 2, 1, 1'b0, 1'b1, -1, 0, 5, -1, 60);
        check_model("restart_busy", 3, 2, 1);

        run_layer(3, 2, 1, 1'b1, 1'b1, -1, 0, -1, 5, 30);
        chk("rst_act_n", act_q.size(), 2);
        chk("rst_out_n", out_q.size(), 0);
        chk("rst_done_n", done_q.size(), 0);
        chk("rst_busy_last", busy_last, 4);
        run_layer(3, 2, 1, 1'b1, 1'b0, -1, 0, -1, -1, 60);
        check_model("after_rst", 3, 2, 1);

        run_layer(255, 1, 1, 1'b0, 1'b0, -1, 0, -1, -1, 300);
        check_model("wide_255", 255, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
